acc4_seq: RTL and testbench
===========================

ACC4_SEQ -- requirements
Module: acc4_seq

Interface
REQ-001 SHALL have parameter N_OPS, default 4, meaning the number of operands summed per result (legal 1..15).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port clear, input, 1, synchronous abort of the current accumulation.
REQ-005 SHALL have port in_valid, input, 1, operand present.
REQ-006 SHALL have port in_ready, output, 1, block accepts an operand.
REQ-007 SHALL have port in_data, input, 4, unsigned operand.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port out_sum, output, 4, accumulated sum.
REQ-011 SHALL have port out_ovf, output, 1, sticky carry-out seen during the accumulation.

Function
REQ-012 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-013 SHALL define an input handshake as in_valid & in_ready on a rising edge, and an output handshake as out_valid & out_ready on a rising edge.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DONE, decoded from state only, with no combinational path from in_valid.
REQ-015 SHALL, on a handshake in IDLE: set acc=in_data, cnt=1, ovf=0, then go to ACCUM, or to DONE if N_OPS==1.
REQ-016 SHALL, on a handshake in ACCUM: set acc=acc+in_data through a 4-bit adder, ovf |= carry-out, cnt+1, and go to DONE when the new cnt equals N_OPS.
REQ-017 SHALL hold all state in IDLE and ACCUM on cycles without a handshake, so gaps in in_valid are tolerated.
REQ-018 SHALL assert out_valid exactly in DONE, i.e. one cycle after the N_OPS-th accepted operand.
REQ-019 SHALL hold out_sum and out_ovf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on an output handshake, zero acc, cnt and ovf and go to IDLE; the next operand is accepted no earlier than the following cycle.
REQ-021 SHALL give clear priority over every handshake: on clear=1, go to IDLE, zero acc, cnt and ovf, deassert out_valid, and discard any simultaneous operand or result.
REQ-022 SHALL drive out_sum and out_ovf directly from registers (acc, ovf).

Reset
REQ-023 SHALL, while rst_n=0, immediately force state=IDLE, acc=0, cnt=0, ovf=0, giving in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-024 SHALL abandon any in-progress accumulation or pending result when reset is asserted mid-operation, with no residue after release.

Configuration
REQ-025 SHALL, with ACC4_SEQ_SAT_EN defined, saturate: on any carry-out set acc=4'hF, and hold it at 4'hF for the rest of the accumulation, with ovf=1.
REQ-026 SHALL, without ACC4_SEQ_SAT_EN, wrap the sum modulo 16, with ovf recording only that a carry occurred.

Structure
REQ-027 SHALL place the state enum (IDLE/ACCUM/DONE), DATA_W=4 and CNT_W=4 in shared package acc4_pkg.
REQ-028 SHALL instantiate one sub-module, add4c: a 4-bit ripple adder with carry-out built from two chained fadd2 stages with cin=0.

Verification
REQ-029 SHALL cover: reset, feed 1,2,3,4 back-to-back -> out_valid the cycle after the 4th operand, out_sum=4'hA, out_ovf=0.
REQ-030 SHALL cover: feed 8,8,1,1 -> out_sum=4'h2, out_ovf=1 without the macro; out_sum=4'hF, out_ovf=1 with ACC4_SEQ_SAT_EN.
REQ-031 SHALL cover: result pending with out_ready=0 for 5 cycles while in_valid=1 -> out_valid held, in_ready=0, out_sum stable, no operand consumed.
REQ-032 SHALL cover: clear after operands 5,5, then feed 1,1,1,1 -> out_sum=4'h4, out_ovf=0.
REQ-033 SHALL cover: rst_n dropped mid-cycle in ACCUM -> outputs reach reset values before the next clock edge, and the first result after release is correct.
REQ-034 SHALL cover: operands 3,3,3,3 with 2 idle cycles between each, and clear=1 coincident with an input handshake -> out_sum=4'hC without gaps affecting it; the coincident operand is dropped.

Source files
------------

// File: rtl/acc4_pkg.sv
// Shared types and widths for the acc4_seq accumulator slice.
package acc4_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/acc4_seq_add4c.sv
// 4-bit ripple adder with carry-out (add4c), built from two chained 2-bit stages (fadd2).
module fadd2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

module add4c (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);

    logic carry_mid;

    fadd2 u_lo (
        .a    (a[1:0]),
        .b    (b[1:0]),
        .cin  (1'b0),
        .sum  (sum[1:0]),
        .cout (carry_mid)
    );

    fadd2 u_hi (
        .a    (a[3:2]),
        .b    (b[3:2]),
        .cin  (carry_mid),
        .sum  (sum[3:2]),
        .cout (cout)
    );

endmodule

// File: rtl/acc4_seq.sv
// Sums N_OPS 4-bit operands per result with a sticky carry flag.
// Define ACC4_SEQ_SAT_EN to saturate at 4'hF instead of wrapping modulo 16.
module acc4_seq
    import acc4_pkg::*;
#(
    parameter int N_OPS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_OPS);

    state_t            state, state_next;
    logic [DATA_W-1:0] acc, acc_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ovf, ovf_next;

    logic [DATA_W-1:0] add_sum;
    logic              add_carry;
    logic [DATA_W-1:0] acc_add;
    logic [CNT_W-1:0]  cnt_inc;

    add4c u_add (
        .a    (acc),
        .b    (in_data),
        .sum  (add_sum),
        .cout (add_carry)
    );

`ifdef ACC4_SEQ_SAT_EN
    // Once any carry has been seen the sum pins at all-ones until the result is taken.
    assign acc_add = (add_carry || ovf) ? {DATA_W{1'b1}} : add_sum;
`else
    assign acc_add = add_sum;
`endif

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;

        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_next   = in_data;
                        cnt_next   = CNT_W'(1);
                        ovf_next   = 1'b0;
                        state_next = (N_OPS == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_next = acc_add;
                        ovf_next = ovf | add_carry;
                        cnt_next = cnt_inc;
                        if (cnt_inc == N_LAST) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_acc4_seq.sv
// Self-checking bench for acc4_seq: directed scenarios plus random traffic against an operand-list model.
module tb_acc4_seq;

    localparam int N_OPS = 4;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_ovf;

    int tests = 0;
    int fails = 0;

    acc4_seq #(.N_OPS(N_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the operands accepted so far in this accumulation, and whether a result is waiting.
    int ops[$];
    bit pending;

    function automatic int ops_total();
        int t = 0;
        foreach (ops[i]) t += ops[i];
        return t;
    endfunction

    function automatic logic [3:0] exp_sum();
        int t = ops_total();
`ifdef ACC4_SEQ_SAT_EN
        return (t > 15) ? 4'hF : 4'(t);
`else
        return 4'(t % 16);
`endif
    endfunction

    function automatic logic exp_ovf();
        return ops_total() > 15;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops.delete();
            pending = 1'b0;
        end else if (clear) begin
            ops.delete();
            pending = 1'b0;
        end else if (pending) begin
            if (out_ready) begin
                ops.delete();
                pending = 1'b0;
            end
        end else if (in_valid) begin
            ops.push_back(int'(in_data));
            if (ops.size() == N_OPS) pending = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready",  in_ready,  !pending);
        check("cmp_out_valid", out_valid, pending);
        check("cmp_out_sum",   out_sum,   exp_sum());
        check("cmp_out_ovf",   out_ovf,   exp_ovf());
    end

    // Called at a falling edge; returns at a falling edge.
    task automatic feed(input logic [3:0] d, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready",  in_ready,  1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_sum",   out_sum,   4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1,2,3,4 back to back
        feed(4'd1, 0); feed(4'd2, 0); feed(4'd3, 0);
        check("seq1234_not_early", out_valid, 1'b0);
        feed(4'd4, 0);
        check("seq1234_valid", out_valid, 1'b1);
        check("seq1234_sum",   out_sum,   4'hA);
        check("seq1234_ovf",   out_ovf,   1'b0);
        take();
        check("seq1234_taken", out_valid, 1'b0);

        // 8,8,1,1 overflow
        feed(4'd8, 0); feed(4'd8, 0); feed(4'd1, 0); feed(4'd1, 0);
        check("ovf_valid", out_valid, 1'b1);
`ifdef ACC4_SEQ_SAT_EN
        check("ovf_sum", out_sum, 4'hF);
`else
        check("ovf_sum", out_sum, 4'h2);
`endif
        check("ovf_flag", out_ovf, 1'b1);
        take();

        // Backpressure while operands are offered
        feed(4'd1, 0); feed(4'd1, 0); feed(4'd1, 0); feed(4'd1, 0);
        in_valid = 1'b1;
        in_data  = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid",    out_valid, 1'b1);
            check("stall_in_ready", in_ready,  1'b0);
            check("stall_sum",      out_sum,   4'h4);
        end
        in_valid = 1'b0;
        take();
        @(negedge clk);
        check("stall_nothing_consumed", out_sum, 4'h0);

        // Clear after 5,5, then 1,1,1,1
        feed(4'd5, 0); feed(4'd5, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_sum", out_sum, 4'h0);
        feed(4'd1, 0); feed(4'd1, 0); feed(4'd1, 0); feed(4'd1, 0);
        check("after_clear_sum", out_sum, 4'h4);
        check("after_clear_ovf", out_ovf, 1'b0);
        take();

        // Clear coincident with a handshake drops the operand; gapped 3s still sum to C
        feed(4'd2, 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_drop_sum", out_sum, 4'h0);
        feed(4'd3, 2); feed(4'd3, 2); feed(4'd3, 2); feed(4'd3, 0);
        check("gap_valid", out_valid, 1'b1);
        check("gap_sum",   out_sum,   4'hC);
        take();

        // Asynchronous reset mid-accumulation
        feed(4'd6, 0); feed(4'd6, 0);
        #3 rst_n = 1'b0;
        #1;
        check("async_in_ready",  in_ready,  1'b1);
        check("async_out_valid", out_valid, 1'b0);
        check("async_out_sum",   out_sum,   4'h0);
        check("async_out_ovf",   out_ovf,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        feed(4'd2, 0); feed(4'd3, 0); feed(4'd4, 0); feed(4'd5, 0);
        check("post_reset_sum", out_sum, 4'hE);
        check("post_reset_ovf", out_ovf, 1'b0);
        take();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
